// File: rtl/cpstr_unesc.sv
// Escaped-stream decoder: strips ESC_CHAR framing, routing literal bytes to the
// data port and escape codes to a separate out-of-band port.
module cpstr_unesc #(
  parameter logic [7:0] ESC_CHAR = 8'h1B
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_esc_data,
  output logic       o_esc_valid,
  input  logic       i_esc_ready
);

  typedef enum logic {IDLE, GOT_ESC} state_t;

  state_t     state_q;
  logic [7:0] data_q, esc_q;
  logic       dvld_q, evld_q;

  logic accept, dxfer, exfer;

  // Either output being stuck blocks input so decoded order is never reordered.
  assign o_ready = (!dvld_q || i_ready) && (!evld_q || i_esc_ready);
  assign accept  = i_valid && o_ready;
  assign dxfer   = dvld_q && i_ready;
  assign exfer   = evld_q && i_esc_ready;

  assign o_data      = data_q;
  assign o_valid     = dvld_q;
  assign o_esc_data  = esc_q;
  assign o_esc_valid = evld_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      esc_q   <= 8'h00;
      dvld_q  <= 1'b0;
      evld_q  <= 1'b0;
    end else begin
      if (dxfer) dvld_q <= 1'b0;
      if (exfer) evld_q <= 1'b0;
      // A load in the same cycle as a transfer overrides the clear above.
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (i_data == ESC_CHAR) begin
              state_q <= GOT_ESC;
            end else begin
              data_q <= i_data;
              dvld_q <= 1'b1;
            end
          end
          GOT_ESC: begin
            state_q <= IDLE;
            if (i_data == ESC_CHAR) begin
              data_q <= ESC_CHAR;
              dvld_q <= 1'b1;
            end else begin
              esc_q  <= i_data;
              evld_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpstr_unesc.sv
// Bench for cpstr_unesc: directed scenarios then random traffic, checked against
// a stream-level decode of every accepted byte into expected data/escape queues.
module tb_cpstr_unesc;

  localparam logic [7:0] ESC = 8'h1B;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_esc_data;
  logic       o_esc_valid;
  logic       i_esc_ready = 1'b0;

  cpstr_unesc #(.ESC_CHAR(ESC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_esc_data(o_esc_data), .o_esc_valid(o_esc_valid), .i_esc_ready(i_esc_ready)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] dq[$];
  logic [7:0] eq[$];
  bit pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; all checks derive from the decode rules and the
  // handshake rules, evaluated on what was observed before the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic ir, input logic er);
    logic acc, dtx, etx, pv, pev, gotd, gote;
    logic [7:0] pd, ped, nd, ne;
    @(negedge i_clk);
    i_valid = v; i_data = d; i_ready = ir; i_esc_ready = er;
    #1;
    chk("ready_rule", o_ready, (!o_valid || ir) && (!o_esc_valid || er));
    acc = v && o_ready;
    dtx = o_valid && ir;
    etx = o_esc_valid && er;
    pv = o_valid; pd = o_data; pev = o_esc_valid; ped = o_esc_data;
    gotd = 0; gote = 0; nd = 8'h00; ne = 8'h00;
    if (dtx) begin
      if (dq.size() == 0) chk("data_unexpected", 32'(o_data), 32'hFFFF_FFFF);
      else chk("data_order", o_data, dq.pop_front());
    end
    if (etx) begin
      if (eq.size() == 0) chk("esc_unexpected", 32'(o_esc_data), 32'hFFFF_FFFF);
      else chk("esc_order", o_esc_data, eq.pop_front());
    end
    if (acc) begin
      if (!pend) begin
        if (d == ESC) pend = 1;
        else begin gotd = 1; nd = d; end
      end else begin
        pend = 0;
        if (d == ESC) begin gotd = 1; nd = ESC; end
        else begin gote = 1; ne = d; end
      end
      if (gotd) dq.push_back(nd);
      if (gote) eq.push_back(ne);
    end
    @(posedge i_clk);
    #1;
    chk("o_valid", o_valid, gotd || (pv && !dtx));
    if (gotd) chk("o_data_load", o_data, nd);
    else if (pv && !dtx) chk("o_data_hold", o_data, pd);
    chk("o_esc_valid", o_esc_valid, gote || (pev && !etx));
    if (gote) chk("o_esc_load", o_esc_data, ne);
    else if (pev && !etx) chk("o_esc_hold", o_esc_data, ped);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1; i_valid = 1; i_data = 8'h07; i_ready = 0; i_esc_ready = 0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_esc_valid", o_esc_valid, 0);
    chk("rst_o_data", o_data, 8'h00);
    chk("rst_o_esc_data", o_esc_data, 8'h00);
    chk("rst_o_ready", o_ready, 1);
    @(posedge i_clk);
    #1;
    chk("rst_edge_o_valid", o_valid, 0);
    chk("rst_edge_o_data", o_data, 8'h00);
    @(negedge i_clk);
    i_rst = 0; i_valid = 0;
    #1;
    chk("post_rst_o_ready", o_ready, 1);
    pend = 0;
    dq.delete();
    eq.delete();
  endtask

  initial begin
    logic [7:0] b;
    do_reset();

    // plain stream
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 1, 1);
    step(0, 8'h00, 1, 1);

    // literal escape pair then plain byte
    step(1, ESC, 1, 1); step(1, ESC, 1, 1); step(1, 8'h07, 1, 1);
    step(0, 8'h00, 1, 1);

    // escape code between data bytes
    step(1, 8'h06, 1, 1); step(1, ESC, 1, 1); step(1, 8'hBE, 1, 1); step(1, 8'h08, 1, 1);
    step(0, 8'h00, 1, 1);

    // downstream stall
    step(1, 8'h10, 0, 1);
    step(1, 8'h11, 0, 1); step(1, 8'h11, 0, 1); step(1, 8'h11, 0, 1);
    step(1, 8'h11, 1, 1); step(1, 8'h12, 1, 1);
    step(0, 8'h00, 1, 1); step(0, 8'h00, 1, 1);

    // escape-port stall blocks the following data byte
    step(1, ESC, 1, 0); step(1, 8'hC3, 1, 0);
    step(1, 8'h20, 1, 0); step(1, 8'h20, 1, 0);
    chk("esc_block_no_data", o_valid, 0);
    step(1, 8'h20, 1, 1);
    step(0, 8'h00, 1, 1);

    // back-to-back escape codes
    step(1, ESC, 1, 1); step(1, 8'h55, 1, 1); step(1, ESC, 1, 1); step(1, 8'h66, 1, 1);
    step(0, 8'h00, 1, 1);

    // reset while an escape is pending
    step(1, ESC, 1, 1);
    do_reset();
    step(1, 8'h41, 1, 1);
    chk("after_rst_no_esc", o_esc_valid, 0);
    step(0, 8'h00, 1, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 9) < 3) ? ESC : 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), b,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1);
    chk("drain_data", dq.size(), 0);
    chk("drain_esc", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
